// File: rtl/msg_decrypt_engine_if.sv
// msg_decrypt_engine_if: Start/Ack handshake and single-port data-memory bus of the decrypt engine
interface msg_decrypt_engine_if;
  logic       Start;
  logic [7:0] MemAddr;
  logic [7:0] MemDataIn;
  logic [7:0] MemDataOut;
  logic       MemWrEn;
  logic       Ack;
  logic       Err;
  logic [3:0] PatIdx;
  modport master (input Start, MemDataIn, output MemAddr, MemDataOut, MemWrEn, Ack, Err, PatIdx);
  modport slave (output Start, MemDataIn, input MemAddr, MemDataOut, MemWrEn, Ack, Err, PatIdx);
endinterface

// File: rtl/msg_decrypt_engine.sv
// msg_decrypt_engine: recovers LFSR tap/seed from the space preamble and decrypts ciphertext in data memory
module msg_decrypt_engine #(
  parameter logic [7:0] MSG_BASE = 8'd64,
  parameter logic [7:0] OUT_BASE = 8'd0,
  parameter int         MSG_LEN  = 64,
  parameter int         PRE_CHK  = 10,
  parameter logic [7:0] SPACE    = 8'h20
) (
  input logic Clk,
  input logic Reset,
  msg_decrypt_engine_if.master bus
);
  typedef enum logic [2:0] {IDLE, SEED, SEARCH, SCAN, DEC_RD, DEC_WR, PAD, DONE} state_t;
  localparam logic [7:0] PRE_LAST = 8'(MSG_BASE + PRE_CHK - 1);
  localparam logic [7:0] OUT_END  = 8'(OUT_BASE + MSG_LEN);
  localparam logic [7:0] OUT_LAST = 8'(OUT_BASE + MSG_LEN - 1);
  localparam logic [6:0] LAST_J   = 7'(MSG_LEN - 1);
  state_t     state_q;
  logic [7:0] addr_q, dout_q;
  logic       wr_q, ack_q, err_q, start_q;
  logic [3:0] p_q, pat_q;
  logic [6:0] s0_q, lfsr_q, j_q, k_q;
  logic [6:0] tap, nxt, c_sp;
  logic [7:0] c, d;
  logic       good;
  assign c    = bus.MemDataIn;
  assign c_sp = c[6:0] ^ SPACE[6:0];
  assign nxt  = {lfsr_q[5:0], ^(lfsr_q & tap)};
  assign good = c[7] == ^c[6:0];
  // bad-parity bytes decode to a marker that can never be mistaken for a space
  assign d    = good ? {1'b0, c[6:0] ^ lfsr_q} : 8'h80;
  assign bus.MemAddr    = addr_q;
  assign bus.MemDataOut = dout_q;
  assign bus.MemWrEn    = wr_q;
  assign bus.Ack        = ack_q;
  assign bus.Err        = err_q;
  assign bus.PatIdx     = pat_q;
  // candidate tap pattern ROM, searched lowest index first
  always_comb begin
    case (p_q)
      4'd0:    tap = 7'h60;
      4'd1:    tap = 7'h48;
      4'd2:    tap = 7'h78;
      4'd3:    tap = 7'h72;
      4'd4:    tap = 7'h6A;
      4'd5:    tap = 7'h69;
      4'd6:    tap = 7'h5C;
      4'd7:    tap = 7'h7E;
      default: tap = 7'h7B;
    endcase
  end
  // control FSM; the registered address/strobe describe this cycle's single memory access
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      pat_q   <= '0;
      start_q <= 1'b0;
      p_q     <= '0;
      s0_q    <= '0;
      lfsr_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      start_q <= bus.Start;
      case (state_q)
        IDLE: if (start_q && !bus.Start) begin
          state_q <= SEED;
          addr_q  <= MSG_BASE;
        end
        SEED: begin
          s0_q    <= c_sp;
          lfsr_q  <= c_sp;
          p_q     <= '0;
          addr_q  <= MSG_BASE + 8'd1;
          state_q <= SEARCH;
        end
        SEARCH:
          if (nxt == c_sp) begin
            if (addr_q == PRE_LAST) begin
              pat_q   <= p_q;
              lfsr_q  <= s0_q;
              j_q     <= '0;
              addr_q  <= MSG_BASE;
              state_q <= SCAN;
            end else begin
              lfsr_q <= nxt;
              addr_q <= addr_q + 8'd1;
            end
          end else if (p_q == 4'd8) begin
            err_q   <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            p_q    <= p_q + 4'd1;
            lfsr_q <= s0_q;
            addr_q <= MSG_BASE + 8'd1;
          end
        SCAN:
          if (d != SPACE) begin
            k_q     <= j_q;
            state_q <= DEC_RD;
          end else if (j_q == LAST_J) begin
            k_q     <= 7'(MSG_LEN);
            addr_q  <= OUT_BASE;
            dout_q  <= SPACE;
            wr_q    <= 1'b1;
            state_q <= PAD;
          end else begin
            lfsr_q <= nxt;
            j_q    <= j_q + 7'd1;
            addr_q <= addr_q + 8'd1;
          end
        DEC_RD: begin
          addr_q  <= OUT_BASE + {1'b0, j_q - k_q};
          dout_q  <= d;
          wr_q    <= 1'b1;
          lfsr_q  <= nxt;
          state_q <= DEC_WR;
        end
        DEC_WR:
          if (j_q == LAST_J) begin
            if (k_q == 7'd0) begin
              wr_q    <= 1'b0;
              ack_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q  <= OUT_END - {1'b0, k_q};
              dout_q  <= SPACE;
              state_q <= PAD;
            end
          end else begin
            j_q     <= j_q + 7'd1;
            addr_q  <= MSG_BASE + {1'b0, j_q} + 8'd1;
            wr_q    <= 1'b0;
            state_q <= DEC_RD;
          end
        PAD:
          if (addr_q == OUT_LAST) begin
            wr_q    <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            addr_q <= addr_q + 8'd1;
          end
        DONE: if (bus.Start) begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msg_decrypt_engine.sv
// tb_msg_decrypt_engine: scoreboard bench driving directed ciphertexts through a behavioural data memory
module tb_msg_decrypt_engine;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic load = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [256];
  logic [7:0] img [128];
  logic [7:0] exp_out [64];
  logic [15:0] wq [$];
  logic [6:0] rq [$];
  logic [15:0] we;
  logic [6:0] re;
  logic prev_ack = 1'b0;
  logic prev_wr = 1'b0;
  localparam string MSG1 = "Mr. Watson, come here. I want to see you.";

  msg_decrypt_engine_if bus();
  msg_decrypt_engine dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  assign bus.MemDataIn = mem[bus.MemAddr];
  always @(posedge Clk) begin
    if (load) for (int a = 0; a < 128; a++) mem[a] <= img[a];
    else if (bus.MemWrEn) mem[bus.MemAddr] <= bus.MemDataOut;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // monitor: every write and every Ack rise is matched against the scoreboard queues
  always @(negedge Clk) begin
    if (!Reset && bus.MemWrEn) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", bus.MemAddr, bus.MemDataOut);
      end else begin
        we = wq.pop_front();
        if ({bus.MemAddr, bus.MemDataOut} !== we) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h", bus.MemAddr, bus.MemDataOut, we[15:8], we[7:0]);
        end
      end
    end
    if (!Reset && bus.Ack && !prev_ack) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack");
      end else begin
        re = rq.pop_front();
        check("err_flag", bus.Err, re[6]);
        if (re[1]) check("pat_idx", bus.PatIdx, re[5:2]);
        check("ack_after_last_write", prev_wr, re[0]);
      end
      check("writes_outstanding", wq.size(), 0);
    end
    prev_ack = bus.Ack;
    prev_wr = bus.MemWrEn;
  end

  // program-1 encrypter: pre spaces, message, space pad, 7-bit LFSR xor, bit 7 = parity
  task automatic encrypt(logic [6:0] tap, logic [6:0] seed, int pre, string m);
    logic [6:0] l = seed;
    logic [7:0] p;
    logic [6:0] c7;
    for (int j = 0; j < 64; j++) begin
      p = (j < pre || j - pre >= m.len()) ? 8'h20 : m[j - pre];
      c7 = p[6:0] ^ l;
      img[64 + j] = {^c7, c7};
      img[j] = 8'h00;
      l = {l[5:0], ^(l & tap)};
    end
  endtask

  task automatic load_mem();
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
  endtask

  task automatic expect_msg(string m, int bad, logic [3:0] pidx);
    logic [7:0] v;
    for (int j = 0; j < 64; j++) begin
      v = (j == bad) ? 8'h80 : (j < m.len()) ? m[j] : 8'h20;
      exp_out[j] = v;
      wq.push_back({8'(j), v});
    end
    rq.push_back({1'b0, pidx, 1'b1, 1'b1});
  endtask

  task automatic expect_err();
    for (int j = 0; j < 64; j++) exp_out[j] = 8'h00;
    rq.push_back({1'b1, 4'd0, 1'b0, 1'b0});
  endtask

  task automatic run(string name);
    int n = 0;
    int bad_out = 0;
    int bad_ct = 0;
    bus.Start = 1'b1;
    repeat (2) @(negedge Clk);
    bus.Start = 1'b0;
    do begin
      @(negedge Clk);
      n++;
    end while (!bus.Ack && n < 400);
    checks++;
    if (!bus.Ack || n > 354) begin
      errors++;
      $display("FAIL %s ack_latency got=%0d cycles ack=%0b want<=354", name, n, bus.Ack);
    end
    bus.Start = 1'b1;
    @(negedge Clk);
    check({name, " ack_clear"}, bus.Ack, 0);
    check({name, " err_clear"}, bus.Err, 0);
    for (int i = 0; i < 64; i++) begin
      if (mem[i] !== exp_out[i]) bad_out++;
      if (mem[64 + i] !== img[64 + i]) bad_ct++;
    end
    check({name, " out_mem_bad_bytes"}, bad_out, 0);
    check({name, " cipher_mem_bad_bytes"}, bad_ct, 0);
  endtask

  initial begin
    int n;
    bus.Start = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst MemAddr", bus.MemAddr, 0);
    check("rst MemDataOut", bus.MemDataOut, 0);
    check("rst MemWrEn", bus.MemWrEn, 0);
    check("rst Ack", bus.Ack, 0);
    check("rst Err", bus.Err, 0);
    check("rst PatIdx", bus.PatIdx, 0);
    Reset = 1'b0;
    encrypt(7'h60, 7'h01, 10, MSG1);
    load_mem();
    expect_msg(MSG1, -1, 4'd0);
    run("s1_watson");
    encrypt(7'h7B, 7'h7F, 15, "A");
    load_mem();
    expect_msg("A", -1, 4'd8);
    run("s2_tap8");
    encrypt(7'h60, 7'h01, 10, MSG1);
    img[84] = img[84] ^ 8'h80;
    load_mem();
    expect_msg(MSG1, 10, 4'd0);
    run("s3_parity");
    encrypt(7'h60, 7'h01, 10, MSG1);
    img[67] = img[67] ^ 8'hC0;
    load_mem();
    expect_err();
    run("s4_nomatch");
    encrypt(7'h72, 7'h2A, 10, "");
    load_mem();
    expect_msg("", -1, 4'd3);
    run("s5_allspace");
    encrypt(7'h60, 7'h01, 10, MSG1);
    load_mem();
    expect_msg(MSG1, -1, 4'd0);
    bus.Start = 1'b1;
    repeat (2) @(negedge Clk);
    bus.Start = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!bus.MemWrEn && n < 400);
    check("s6 decode_reached", bus.MemWrEn, 1);
    #1 Reset = 1'b1;
    @(negedge Clk);
    check("s6 abort MemWrEn", bus.MemWrEn, 0);
    check("s6 abort Ack", bus.Ack, 0);
    #1 Reset = 1'b0;
    wq.delete();
    rq.delete();
    expect_msg(MSG1, -1, 4'd0);
    run("s6_rerun");
    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
